// File: rtl/rob_param.sv
// Reorder buffer: circular in-order retirement queue with two writeback
// ports, two operand query ports with same-cycle bypass, registered commit
// and branch-update outputs, and a one-cycle flush on branch mispredict.
module rob_param #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              alloc_valid_in,
    output logic              alloc_ready_out,
    output logic [IDX_W-1:0]  alloc_idx_out,
    input  logic [1:0]        alloc_op_in,
    input  logic [4:0]        alloc_dest_in,
    input  logic              alloc_done_in,
    input  logic [DATA_W-1:0] alloc_val_in,
    input  logic              alloc_pred_in,
    input  logic [ADDR_W-1:0] alloc_pc_in,
    input  logic [ADDR_W-1:0] alloc_alt_pc_in,
    input  logic              wb0_en_in,
    input  logic [IDX_W-1:0]  wb0_idx_in,
    input  logic [DATA_W-1:0] wb0_val_in,
    input  logic              wb1_en_in,
    input  logic [IDX_W-1:0]  wb1_idx_in,
    input  logic [DATA_W-1:0] wb1_val_in,
    input  logic [IDX_W-1:0]  q1_idx_in,
    output logic              q1_ready_out,
    output logic [DATA_W-1:0] q1_val_out,
    input  logic [IDX_W-1:0]  q2_idx_in,
    output logic              q2_ready_out,
    output logic [DATA_W-1:0] q2_val_out,
    output logic              commit_en_out,
    output logic [IDX_W-1:0]  commit_idx_out,
    output logic [1:0]        commit_op_out,
    output logic [4:0]        commit_dest_out,
    output logic [DATA_W-1:0] commit_val_out,
    output logic              br_upd_out,
    output logic [ADDR_W-1:0] br_pc_out,
    output logic              br_taken_out,
    output logic              flush_out,
    output logic [ADDR_W-1:0] flush_pc_out,
    output logic [IDX_W:0]    count_out
);

    localparam logic [1:0]       OP_BR    = 2'd1;
    localparam logic [IDX_W:0]   DEPTH_C  = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W:0]   CNT_ZERO = (IDX_W+1)'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    // Queue pointers and occupancy
    logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]    count_q, count_d;

    // Per-entry storage
    logic              busy_q   [DEPTH];
    logic              busy_d   [DEPTH];
    logic              done_q   [DEPTH];
    logic              done_d   [DEPTH];
    logic [1:0]        op_q     [DEPTH];
    logic [1:0]        op_d     [DEPTH];
    logic [4:0]        dest_q   [DEPTH];
    logic [4:0]        dest_d   [DEPTH];
    logic [DATA_W-1:0] val_q    [DEPTH];
    logic [DATA_W-1:0] val_d    [DEPTH];
    logic              pred_q   [DEPTH];
    logic              pred_d   [DEPTH];
    logic [ADDR_W-1:0] pc_q     [DEPTH];
    logic [ADDR_W-1:0] pc_d     [DEPTH];
    logic [ADDR_W-1:0] alt_pc_q [DEPTH];
    logic [ADDR_W-1:0] alt_pc_d [DEPTH];

    // Registered outputs
    logic              commit_en_q, commit_en_d;
    logic [IDX_W-1:0]  commit_idx_q, commit_idx_d;
    logic [1:0]        commit_op_q, commit_op_d;
    logic [4:0]        commit_dest_q, commit_dest_d;
    logic [DATA_W-1:0] commit_val_q, commit_val_d;
    logic              br_upd_q, br_upd_d;
    logic [ADDR_W-1:0] br_pc_q, br_pc_d;
    logic              br_taken_q, br_taken_d;
    logic              flush_q, flush_d;
    logic [ADDR_W-1:0] flush_pc_q, flush_pc_d;

    // Per-cycle events
    logic active_s, retire_s, mispredict_s, alloc_ready_s, alloc_fire_s;
    logic wb0_acc_s, wb1_acc_s;

    // Decide which events fire this cycle; nothing moves while stalled or flushing
    always_comb begin
        active_s      = rdy_in && !flush_q;
        retire_s      = active_s && (count_q != CNT_ZERO) && done_q[head_q];
        mispredict_s  = retire_s && (op_q[head_q] == OP_BR)
                        && (val_q[head_q][0] != pred_q[head_q]);
        // A retiring head frees a slot in the same cycle, so a full queue can still accept
        alloc_ready_s = !flush_q && ((count_q < DEPTH_C) || retire_s);
        alloc_fire_s  = alloc_valid_in && alloc_ready_s && rdy_in;
        wb0_acc_s     = wb0_en_in && active_s && busy_q[wb0_idx_in]
                        && !(alloc_fire_s && (wb0_idx_in == tail_q));
        wb1_acc_s     = wb1_en_in && active_s && busy_q[wb1_idx_in]
                        && !(alloc_fire_s && (wb1_idx_in == tail_q));
    end

    // Next-state for pointers and entries: writeback, then retire, then allocate
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = done_q;
        op_d     = op_q;
        dest_d   = dest_q;
        val_d    = val_q;
        pred_d   = pred_q;
        pc_d     = pc_q;
        alt_pc_d = alt_pc_q;
        // wb1 first so wb0 overrides on an index collision
        if (wb1_acc_s) begin
            done_d[wb1_idx_in] = 1'b1;
            val_d[wb1_idx_in]  = wb1_val_in;
        end else begin
            done_d = done_d;
        end
        if (wb0_acc_s) begin
            done_d[wb0_idx_in] = 1'b1;
            val_d[wb0_idx_in]  = wb0_val_in;
        end else begin
            done_d = done_d;
        end
        if (retire_s) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + IDX_ONE;
        end else begin
            head_d = head_q;
        end
        if (alloc_fire_s) begin
            busy_d[tail_q]   = 1'b1;
            done_d[tail_q]   = alloc_done_in;
            op_d[tail_q]     = alloc_op_in;
            dest_d[tail_q]   = alloc_dest_in;
            val_d[tail_q]    = alloc_val_in;
            pred_d[tail_q]   = alloc_pred_in;
            pc_d[tail_q]     = alloc_pc_in;
            alt_pc_d[tail_q] = alloc_alt_pc_in;
            tail_d           = tail_q + IDX_ONE;
        end else begin
            tail_d = tail_q;
        end
        count_d = count_q + (alloc_fire_s ? CNT_ONE : CNT_ZERO)
                          - (retire_s ? CNT_ONE : CNT_ZERO);
        // A mispredicted branch squashes everything younger, including this cycle's allocation
        if (mispredict_s) begin
            head_d  = IDX_ZERO;
            tail_d  = IDX_ZERO;
            count_d = CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                busy_d[i] = 1'b0;
                done_d[i] = 1'b0;
            end
        end else begin
            count_d = count_d;
        end
    end

    // Next value of the registered commit/branch/flush outputs; held while stalled
    always_comb begin
        commit_en_d   = commit_en_q;
        commit_idx_d  = commit_idx_q;
        commit_op_d   = commit_op_q;
        commit_dest_d = commit_dest_q;
        commit_val_d  = commit_val_q;
        br_upd_d      = br_upd_q;
        br_pc_d       = br_pc_q;
        br_taken_d    = br_taken_q;
        flush_d       = flush_q;
        flush_pc_d    = flush_pc_q;
        if (rdy_in) begin
            commit_en_d   = retire_s;
            commit_idx_d  = head_q;
            commit_op_d   = op_q[head_q];
            commit_dest_d = dest_q[head_q];
            commit_val_d  = val_q[head_q];
            br_upd_d      = retire_s && (op_q[head_q] == OP_BR);
            br_pc_d       = pc_q[head_q];
            br_taken_d    = val_q[head_q][0];
            flush_d       = mispredict_s;
            flush_pc_d    = alt_pc_q[head_q];
        end else begin
            commit_en_d = commit_en_q;
        end
    end

    // Operand query 1: wb0 bypass, then wb1, then same-cycle complete allocation, then storage
    always_comb begin
        q1_ready_out = busy_q[q1_idx_in] && done_q[q1_idx_in];
        q1_val_out   = val_q[q1_idx_in];
        if (wb0_acc_s && (wb0_idx_in == q1_idx_in)) begin
            q1_ready_out = 1'b1;
            q1_val_out   = wb0_val_in;
        end else if (wb1_acc_s && (wb1_idx_in == q1_idx_in)) begin
            q1_ready_out = 1'b1;
            q1_val_out   = wb1_val_in;
        end else if (alloc_fire_s && alloc_done_in && (tail_q == q1_idx_in)) begin
            q1_ready_out = 1'b1;
            q1_val_out   = alloc_val_in;
        end else begin
            q1_val_out = q1_val_out;
        end
    end

    // Operand query 2: same priority as query 1
    always_comb begin
        q2_ready_out = busy_q[q2_idx_in] && done_q[q2_idx_in];
        q2_val_out   = val_q[q2_idx_in];
        if (wb0_acc_s && (wb0_idx_in == q2_idx_in)) begin
            q2_ready_out = 1'b1;
            q2_val_out   = wb0_val_in;
        end else if (wb1_acc_s && (wb1_idx_in == q2_idx_in)) begin
            q2_ready_out = 1'b1;
            q2_val_out   = wb1_val_in;
        end else if (alloc_fire_s && alloc_done_in && (tail_q == q2_idx_in)) begin
            q2_ready_out = 1'b1;
            q2_val_out   = alloc_val_in;
        end else begin
            q2_val_out = q2_val_out;
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q        <= IDX_ZERO;
            tail_q        <= IDX_ZERO;
            count_q       <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i]   <= 1'b0;
                done_q[i]   <= 1'b0;
                op_q[i]     <= 2'd0;
                dest_q[i]   <= 5'd0;
                val_q[i]    <= {DATA_W{1'b0}};
                pred_q[i]   <= 1'b0;
                pc_q[i]     <= {ADDR_W{1'b0}};
                alt_pc_q[i] <= {ADDR_W{1'b0}};
            end
            commit_en_q   <= 1'b0;
            commit_idx_q  <= IDX_ZERO;
            commit_op_q   <= 2'd0;
            commit_dest_q <= 5'd0;
            commit_val_q  <= {DATA_W{1'b0}};
            br_upd_q      <= 1'b0;
            br_pc_q       <= {ADDR_W{1'b0}};
            br_taken_q    <= 1'b0;
            flush_q       <= 1'b0;
            flush_pc_q    <= {ADDR_W{1'b0}};
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            op_q          <= op_d;
            dest_q        <= dest_d;
            val_q         <= val_d;
            pred_q        <= pred_d;
            pc_q          <= pc_d;
            alt_pc_q      <= alt_pc_d;
            commit_en_q   <= commit_en_d;
            commit_idx_q  <= commit_idx_d;
            commit_op_q   <= commit_op_d;
            commit_dest_q <= commit_dest_d;
            commit_val_q  <= commit_val_d;
            br_upd_q      <= br_upd_d;
            br_pc_q       <= br_pc_d;
            br_taken_q    <= br_taken_d;
            flush_q       <= flush_d;
            flush_pc_q    <= flush_pc_d;
        end
    end

    assign alloc_ready_out = alloc_ready_s;
    assign alloc_idx_out   = tail_q;
    assign commit_en_out   = commit_en_q;
    assign commit_idx_out  = commit_idx_q;
    assign commit_op_out   = commit_op_q;
    assign commit_dest_out = commit_dest_q;
    assign commit_val_out  = commit_val_q;
    assign br_upd_out      = br_upd_q;
    assign br_pc_out       = br_pc_q;
    assign br_taken_out    = br_taken_q;
    assign flush_out       = flush_q;
    assign flush_pc_out    = flush_pc_q;
    assign count_out       = count_q;

endmodule
